// File: rtl/score_ssd_driver.sv
// rtl/score_ssd_driver.sv - binary score to 4-digit multiplexed seven-segment driver
// Sequential double-dabble conversion with a one-deep last-wins request queue.
module score_ssd_driver #(
   parameter int SCORE_W       = 14,
   parameter int SCAN_BITS     = 18,
   parameter int BLANK_LEADING = 1
) (
   input  logic               board_clk,
   input  logic               Reset,
   input  logic [SCORE_W-1:0] score,
   input  logic               score_load,
   output logic               busy,
   output logic [3:0]         anode,
   output logic [6:0]         ssdOut
);

   localparam int CNT_W = $clog2(SCORE_W + 1);

   typedef enum logic {IDLE, CONV} state_t;

   state_t             state;
   logic [SCORE_W-1:0] bin_q;
   logic [SCORE_W-1:0] pend_val;
   logic               pending;
   logic [15:0]        bcd_q;
   logic [15:0]        disp_q;
   logic [CNT_W-1:0]   iter;
   logic [SCAN_BITS-1:0] scan_q;

   function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] v);
      if (32'(v) > 32'd9999) return SCORE_W'(9999);
      return v;
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Top nibble only needs its low 3 bits after add-3; the carry out is shifted away.
   logic [2:0]  top3;
   logic [15:0] bcd_nxt;
   logic        last;
   logic        start_new;
   logic [SCORE_W-1:0] start_val;

   always_comb begin
      top3      = (bcd_q[15:12] >= 4'd5) ? bcd_q[14:12] + 3'd3 : bcd_q[14:12];
      bcd_nxt   = {top3, add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0]),
                   bin_q[SCORE_W-1]};
      last      = (iter == CNT_W'(SCORE_W - 1));
      start_new = score_load | pending;
      start_val = score_load ? clamp(score) : pend_val;
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         pending  <= 1'b0;
         pend_val <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         disp_q   <= '0;
         iter     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (score_load) begin
                  bin_q <= clamp(score);
                  bcd_q <= '0;
                  iter  <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               bcd_q <= bcd_nxt;
               bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
               iter  <= iter + CNT_W'(1);
               if (score_load && !last) begin
                  pending  <= 1'b1;
                  pend_val <= clamp(score);
               end
               if (last) begin
                  disp_q  <= bcd_nxt;
                  pending <= 1'b0;
                  if (start_new) begin
                     bin_q <= start_val;
                     bcd_q <= '0;
                     iter  <= '0;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [1:0] d;
   logic [3:0] nib;
   logic       blank;

   always_comb begin
      d = scan_q[SCAN_BITS-1 -: 2];
      case (d)
         2'd0:    nib = disp_q[3:0];
         2'd1:    nib = disp_q[7:4];
         2'd2:    nib = disp_q[11:8];
         default: nib = disp_q[15:12];
      endcase
      blank = 1'b0;
      if (BLANK_LEADING != 0) begin
         case (d)
            2'd1:    blank = (disp_q[15:4] == 12'd0);
            2'd2:    blank = (disp_q[15:8] == 8'd0);
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            default: blank = 1'b0;
         endcase
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         scan_q <= '0;
         anode  <= 4'b1111;
         ssdOut <= 7'b1111111;
      end else begin
         scan_q <= scan_q + SCAN_BITS'(1);
         anode  <= ~(4'b0001 << d);
         ssdOut <= blank ? 7'b1111111 : seg(nib);
      end
   end

endmodule

// File: tb/tb_score_ssd_driver.sv
// tb/tb_score_ssd_driver.sv - directed self-checking bench for score_ssd_driver
module tb_score_ssd_driver;

   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                          S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                          S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0000100,
                          SB = 7'b1111111;

   logic        board_clk = 1'b0;
   logic        Reset = 1'b1;
   logic [13:0] score = '0;
   logic        score_load = 1'b0;
   logic        busy;
   logic [3:0]  anode;
   logic [6:0]  ssdOut;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 board_clk = ~board_clk;

   score_ssd_driver #(.SCORE_W(14), .SCAN_BITS(4), .BLANK_LEADING(1)) dut (
      .board_clk(board_clk), .Reset(Reset), .score(score), .score_load(score_load),
      .busy(busy), .anode(anode), .ssdOut(ssdOut)
   );

   // Latest segment pattern seen per anode, packed {An3,An2,An1,An0}.
   task automatic record(inout logic [27:0] segs);
      case (anode)
         4'b1110: segs[6:0]   = ssdOut;
         4'b1101: segs[13:7]  = ssdOut;
         4'b1011: segs[20:14] = ssdOut;
         4'b0111: segs[27:21] = ssdOut;
         default: ;
      endcase
   endtask

   task automatic capture(input int n, output logic [27:0] segs);
      segs = 'x;
      for (int i = 0; i < n; i++) begin
         @(negedge board_clk);
         record(segs);
      end
   endtask

   task automatic run_conv(input logic [13:0] v, output int bcyc, output logic [27:0] segs);
      @(negedge board_clk);
      score = v;
      score_load = 1'b1;
      @(posedge board_clk);
      #1 score_load = 1'b0;
      bcyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge board_clk);
         if (busy) bcyc++;
      end
      capture(16, segs);
   endtask

   task automatic test_reset;
      logic [3:0] exp_an;
      logic [6:0] exp_sg;
      repeat (3) @(negedge board_clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL reset_anode: got %b want 1111", anode); end
      n_cmp++; if (ssdOut !== SB) begin n_bad++; $display("FAIL reset_seg: got %b want %b", ssdOut, SB); end
      Reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge board_clk);
         exp_an = ~(4'b0001 << (k / 4));
         exp_sg = (k < 4) ? S0 : SB;
         n_cmp++;
         if (anode !== exp_an) begin n_bad++; $display("FAIL scan_anode[%0d]: got %b want %b", k, anode, exp_an); end
         n_cmp++;
         if (ssdOut !== exp_sg) begin n_bad++; $display("FAIL scan_seg[%0d]: got %b want %b", k, ssdOut, exp_sg); end
      end
   endtask

   task automatic test_convert;
      int bc;
      logic [27:0] s;
      run_conv(14'd1234, bc, s);
      n_cmp++; if (bc !== 14) begin n_bad++; $display("FAIL conv1234_busy: got %0d want 14", bc); end
      n_cmp++; if (s !== {S1, S2, S3, S4}) begin n_bad++; $display("FAIL conv1234_disp: got %h want %h", s, {S1, S2, S3, S4}); end
   endtask

   task automatic test_saturate;
      int bc;
      logic [27:0] s;
      run_conv(14'd16383, bc, s);
      n_cmp++; if (bc !== 14) begin n_bad++; $display("FAIL sat_busy: got %0d want 14", bc); end
      n_cmp++; if (s !== {S9, S9, S9, S9}) begin n_bad++; $display("FAIL sat_disp: got %h want %h", s, {S9, S9, S9, S9}); end
   endtask

   task automatic test_blanking;
      int bc;
      logic [27:0] s;
      run_conv(14'd0, bc, s);
      n_cmp++; if (s !== {SB, SB, SB, S0}) begin n_bad++; $display("FAIL zero_disp: got %h want %h", s, {SB, SB, SB, S0}); end
      run_conv(14'd1005, bc, s);
      n_cmp++; if (s !== {S1, S0, S0, S5}) begin n_bad++; $display("FAIL mid0_disp: got %h want %h", s, {S1, S0, S0, S5}); end
      run_conv(14'd50, bc, s);
      n_cmp++; if (s !== {SB, SB, S5, S0}) begin n_bad++; $display("FAIL fifty_disp: got %h want %h", s, {SB, SB, S5, S0}); end
   endtask

   task automatic test_pending;
      int bc;
      logic b29;
      logic saw7;
      logic [27:0] wa, wb;
      wa = 'x; wb = 'x; bc = 0; b29 = 1'bx; saw7 = 1'b0;
      @(negedge board_clk);
      score = 14'd42;
      score_load = 1'b1;
      @(posedge board_clk);
      #1 score_load = 1'b0;
      for (int k = 1; k <= 46; k++) begin
         @(negedge board_clk);
         if (k <= 28 && busy) bc++;
         if (k == 29) b29 = busy;
         if (anode == 4'b1110 && ssdOut == S7) saw7 = 1'b1;
         if (k >= 16 && k <= 29) record(wa);
         if (k >= 30) record(wb);
         score_load = 1'b0;
         if (k == 3) begin score = 14'd77; score_load = 1'b1; end
         if (k == 6) begin score = 14'd88; score_load = 1'b1; end
      end
      n_cmp++; if (bc !== 28) begin n_bad++; $display("FAIL pend_busy: got %0d want 28", bc); end
      n_cmp++; if (b29 !== 1'b0) begin n_bad++; $display("FAIL pend_idle: got %b want 0", b29); end
      n_cmp++; if (wa !== {SB, SB, S4, S2}) begin n_bad++; $display("FAIL pend_first: got %h want %h", wa, {SB, SB, S4, S2}); end
      n_cmp++; if (wb !== {SB, SB, S8, S8}) begin n_bad++; $display("FAIL pend_last: got %h want %h", wb, {SB, SB, S8, S8}); end
      n_cmp++; if (saw7 !== 1'b0) begin n_bad++; $display("FAIL pend_77_shown: got %b want 0", saw7); end
   endtask

   task automatic test_back_to_back;
      int bc;
      logic b29;
      logic [27:0] wa, wb;
      wa = 'x; wb = 'x; bc = 0; b29 = 1'bx;
      @(negedge board_clk);
      score = 14'd3;
      score_load = 1'b1;
      @(posedge board_clk);
      #1 score_load = 1'b0;
      for (int k = 1; k <= 46; k++) begin
         @(negedge board_clk);
         if (k <= 28 && busy) bc++;
         if (k == 29) b29 = busy;
         if (k >= 16 && k <= 29) record(wa);
         if (k >= 30) record(wb);
         score_load = 1'b0;
         if (k == 14) begin score = 14'd9; score_load = 1'b1; end
      end
      n_cmp++; if (bc !== 28) begin n_bad++; $display("FAIL b2b_busy: got %0d want 28", bc); end
      n_cmp++; if (b29 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", b29); end
      n_cmp++; if (wa !== {SB, SB, SB, S3}) begin n_bad++; $display("FAIL b2b_first: got %h want %h", wa, {SB, SB, SB, S3}); end
      n_cmp++; if (wb !== {SB, SB, SB, S9}) begin n_bad++; $display("FAIL b2b_second: got %h want %h", wb, {SB, SB, SB, S9}); end
   endtask

   task automatic test_reset_abort;
      logic [27:0] s;
      @(negedge board_clk);
      score = 14'd5555;
      score_load = 1'b1;
      @(posedge board_clk);
      #1 score_load = 1'b0;
      repeat (5) @(posedge board_clk);
      #2 Reset = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL abort_anode: got %b want 1111", anode); end
      n_cmp++; if (ssdOut !== SB) begin n_bad++; $display("FAIL abort_seg: got %b want %b", ssdOut, SB); end
      @(negedge board_clk);
      Reset = 1'b0;
      capture(16, s);
      n_cmp++; if (s !== {SB, SB, SB, S0}) begin n_bad++; $display("FAIL abort_disp: got %h want %h", s, {SB, SB, SB, S0}); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got %b want 0", busy); end
      @(negedge board_clk);
      Reset = 1'b1;
      @(negedge board_clk);
      Reset = 1'b0;
      score = 14'd7;
      score_load = 1'b1;
      @(posedge board_clk);
      #1 score_load = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_edge_load: got %b want 1", busy); end
      repeat (20) @(negedge board_clk);
      capture(16, s);
      n_cmp++; if (s !== {SB, SB, SB, S7}) begin n_bad++; $display("FAIL first_edge_disp: got %h want %h", s, {SB, SB, SB, S7}); end
   endtask

   initial begin
      test_reset;
      test_convert;
      test_saturate;
      test_blanking;
      test_pending;
      test_back_to_back;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
